// File: rtl/exe_unit.sv
// Single-cycle registered ALU: arithmetic, logic, shift and compare ops with OF/BF/PF/VF flags.
// Optional rotate-left (opcode 9) is built only when EXE_UNIT_ROTATE_EN is defined.
module exe_unit #(
  parameter int BITS = 8,
  parameter int N    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [BITS-1:0] i_argA,
  input  logic [BITS-1:0] i_argB,
  input  logic [N-1:0]    i_oper,
  output logic [BITS-1:0] o_result,
  output logic            o_OF,
  output logic            o_BF,
  output logic            o_PF,
  output logic            o_VF
);

  localparam int SH  = $clog2(BITS);
  localparam int MSB = BITS - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_MIN = 4'd12;
  localparam logic [3:0] OP_MAX = 4'd13;
  localparam logic [3:0] OP_SLT = 4'd14;

  logic [3:0]      op4;
  logic            hi_op;
  logic [SH-1:0]   amt;
  logic            lt;
  logic [BITS:0]   add_w;
  logic [BITS:0]   sub_w;
  logic [BITS:0]   inc_w;
  logic [BITS:0]   dec_w;
  logic [BITS-1:0] res;
  logic            of;
  logic            bf;
  logic            vf;
  logic            pf;

  assign op4 = i_oper[3:0];
  assign amt = i_argB[SH-1:0];
  assign lt  = $signed(i_argA) < $signed(i_argB);

  // Opcode bits above the low nibble only ever select reserved encodings.
  generate
    if (N > 4) begin : g_hi_op
      assign hi_op = |i_oper[N-1:4];
    end else begin : g_no_hi_op
      assign hi_op = 1'b0;
    end
  endgenerate

  assign add_w = {1'b0, i_argA} + {1'b0, i_argB};
  assign sub_w = {1'b0, i_argA} - {1'b0, i_argB};
  assign inc_w = {1'b0, i_argA} + (BITS+1)'(1);
  assign dec_w = {1'b0, i_argA} - (BITS+1)'(1);

`ifdef EXE_UNIT_ROTATE_EN
  logic [2*BITS-1:0] rot_w;
  assign rot_w = {i_argA, i_argA} << amt;
`endif

  always_comb begin
    res = '0;
    of  = 1'b0;
    bf  = 1'b0;
    vf  = 1'b1;
    case (op4)
      OP_ADD: begin
        {bf, res} = add_w;
        of = (i_argA[MSB] == i_argB[MSB]) && (add_w[MSB] != i_argA[MSB]);
      end
      OP_SUB: begin
        {bf, res} = sub_w;
        of = (i_argA[MSB] != i_argB[MSB]) && (sub_w[MSB] != i_argA[MSB]);
      end
      OP_AND: res = i_argA & i_argB;
      OP_OR:  res = i_argA | i_argB;
      OP_XOR: res = i_argA ^ i_argB;
      OP_NOT: res = ~i_argA;
      OP_SHL: res = i_argA << amt;
      OP_SHR: res = i_argA >> amt;
      OP_SAR: res = $signed(i_argA) >>> amt;
`ifdef EXE_UNIT_ROTATE_EN
      OP_ROL: res = rot_w[2*BITS-1:BITS];
`else
      OP_ROL: vf = 1'b0;
`endif
      OP_INC: begin
        {bf, res} = inc_w;
        of = (i_argA == {1'b0, {(BITS-1){1'b1}}});
      end
      OP_DEC: begin
        {bf, res} = dec_w;
        of = (i_argA == {1'b1, {(BITS-1){1'b0}}});
      end
      OP_MIN: res = lt ? i_argA : i_argB;
      OP_MAX: res = lt ? i_argB : i_argA;
      OP_SLT: res = {{(BITS-1){1'b0}}, lt};
      default: vf = 1'b0;
    endcase
    if (hi_op) vf = 1'b0;
    if (!vf) begin
      res = '0;
      of  = 1'b0;
      bf  = 1'b0;
    end
  end

  assign pf = vf & ~^res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result <= '0;
      o_OF     <= 1'b0;
      o_BF     <= 1'b0;
      o_PF     <= 1'b0;
      o_VF     <= 1'b0;
    end else begin
      o_result <= res;
      o_OF     <= of;
      o_BF     <= bf;
      o_PF     <= pf;
      o_VF     <= vf;
    end
  end

endmodule

// File: tb/tb_exe_unit.sv
// Directed self-checking bench for exe_unit (BITS=8, N=4) with hand-computed expectations.
module tb_exe_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic [7:0] result;
  logic       of_f, bf_f, pf_f, vf_f;

  int checks;
  int failures;

  exe_unit #(.BITS(8), .N(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_argA  (a),
    .i_argB  (b),
    .i_oper  (op),
    .o_result(result),
    .o_OF    (of_f),
    .o_BF    (bf_f),
    .o_PF    (pf_f),
    .o_VF    (vf_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_all(input string tag, input logic [7:0] r, input logic e_of,
                            input logic e_bf, input logic e_pf, input logic e_vf);
    chk({tag, ".result"}, result, r);
    chk({tag, ".OF"}, {7'd0, of_f}, {7'd0, e_of});
    chk({tag, ".BF"}, {7'd0, bf_f}, {7'd0, e_bf});
    chk({tag, ".PF"}, {7'd0, pf_f}, {7'd0, e_pf});
    chk({tag, ".VF"}, {7'd0, vf_f}, {7'd0, e_vf});
  endtask

  // Apply one operation, let one rising edge capture it, sample 1 time unit later.
  task automatic step(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    op       = 4'd0;
    a        = 8'h5A;
    b        = 8'hC3;
    #2;
    expect_all("reset_noclk", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    op = 4'd0; a = 8'h03; b = 8'h04;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_all("add_3_4", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);

    step(4'd0, 8'h7F, 8'h01); expect_all("add_of", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd0, 8'hFF, 8'h01); expect_all("add_carry", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'd1, 8'h00, 8'h01); expect_all("sub_borrow", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'd1, 8'h80, 8'h01); expect_all("sub_of", 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd8, 8'h80, 8'h0B); expect_all("sar_3", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4'd7, 8'h80, 8'h0B); expect_all("shr_3", 8'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd15, 8'h55, 8'hAA); expect_all("reserved15", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd14, 8'hFE, 8'h01); expect_all("slt_neg", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef EXE_UNIT_ROTATE_EN
    step(4'd9, 8'h81, 8'h01); expect_all("rol_1", 8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
`else
    step(4'd9, 8'h81, 8'h01); expect_all("rol_off", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    step(4'd2, 8'hF0, 8'h3C); expect_all("and", 8'h30, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4'd3, 8'hF0, 8'h0E); expect_all("or", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd4, 8'h0F, 8'hFF); expect_all("xor", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4'd5, 8'h0E, 8'h00); expect_all("not", 8'hF1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd6, 8'h01, 8'h08); expect_all("shl_amt0", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd6, 8'h03, 8'h02); expect_all("shl_2", 8'h0C, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4'd10, 8'h7F, 8'h00); expect_all("inc_of", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd10, 8'hFF, 8'h00); expect_all("inc_carry", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'd11, 8'h00, 8'h00); expect_all("dec_borrow", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'd11, 8'h80, 8'h00); expect_all("dec_of", 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'd12, 8'h80, 8'h01); expect_all("min", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd13, 8'h80, 8'h01); expect_all("max", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd14, 8'h01, 8'hFE); expect_all("slt_false", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Mid-stream reset: output must clear without waiting for an edge and stay clear.
    step(4'd0, 8'h7F, 8'h01); expect_all("pre_reset", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 8'hFF, 8'h01); expect_all("held_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd1, 8'h10, 8'h01); expect_all("post_reset", 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_unit.md
EXE_UNIT -- requirements
Module: exe_unit

Interface
REQ-001 The block SHALL have parameter BITS, default 8: operand/result width, at least 4 and a power of two.
REQ-002 The block SHALL have parameter N, default 4: opcode width, at least 4.
REQ-003 The block SHALL have port i_clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_argA, input, BITS bits: operand A, two's complement.
REQ-006 The block SHALL have port i_argB, input, BITS bits: operand B, two's complement.
REQ-007 The block SHALL have port i_oper, input, N bits: opcode.
REQ-008 The block SHALL have port o_result, output, BITS bits: registered result.
REQ-009 The block SHALL have port o_OF, output, 1 bit: signed overflow flag.
REQ-010 The block SHALL have port o_BF, output, 1 bit: carry/borrow flag.
REQ-011 The block SHALL have port o_PF, output, 1 bit: even-parity flag of the result.
REQ-012 The block SHALL have port o_VF, output, 1 bit: result-valid flag (1 = defined opcode).

Function
REQ-013 All outputs SHALL be registered; result and flags for inputs sampled at rising edge k SHALL appear after edge k (latency 1 cycle), with no handshake.
REQ-014 Opcodes SHALL be: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A logical; 7 SHR A logical; 8 SAR A arithmetic; 9 ROL A; 10 INC A+1; 11 DEC A-1; 12 MIN signed; 13 MAX signed; 14 SLT (result 1 if A<B signed, else 0).
REQ-015 Opcode 15 and all opcodes above 15 SHALL be reserved.
REQ-016 Shift and rotate amount SHALL be i_argB[log2(BITS)-1:0]; upper B bits SHALL be ignored, and an amount of 0 SHALL return A.
REQ-017 Arithmetic SHALL be modulo 2^BITS (wrap-around).
REQ-018 o_OF SHALL be set only for ADD/SUB/INC/DEC on two's-complement overflow, and SHALL be 0 for all other opcodes.
REQ-019 o_BF SHALL be carry-out for ADD/INC and borrow (unsigned A<B, or A==0 for DEC) for SUB/DEC, and SHALL be 0 otherwise.
REQ-020 o_PF SHALL be 1 when the result has an even number of 1 bits (XNOR-reduce), for defined opcodes.
REQ-021 For reserved opcodes: o_result=0, o_OF=0, o_BF=0, o_PF=0, o_VF=0.
REQ-022 For defined opcodes o_VF SHALL be 1.

Reset
REQ-023 While i_rst_n=0, all outputs SHALL be 0 immediately (asynchronously), independent of i_clk.
REQ-024 After i_rst_n deasserts, the first valid output SHALL appear after the first rising edge.
REQ-025 Reset asserted mid-stream SHALL discard the pending result without producing a partial output.

Configuration
REQ-026 Macro EXE_UNIT_ROTATE_EN defined: opcode 9 SHALL perform ROL as specified.
REQ-027 EXE_UNIT_ROTATE_EN undefined: opcode 9 SHALL be reserved per REQ-021, and no rotate logic SHALL be synthesized.

Verification (BITS=8, N=4)
REQ-028 The bench SHALL hold i_rst_n=0 with arbitrary inputs and check all outputs = 0 without any clock edge; after release and one edge with ADD 3+4, it SHALL check result 0x07, PF=0, VF=1.
REQ-029 The bench SHALL apply ADD 0x7F+0x01 and check, one cycle later, result 0x80, OF=1, BF=0, PF=0, VF=1; it SHALL apply ADD 0xFF+0x01 and check result 0x00, OF=0, BF=1, PF=1.
REQ-030 The bench SHALL apply SUB 0x00-0x01 and check result 0xFF, BF=1, OF=0, PF=1; it SHALL apply SUB 0x80-0x01 and check result 0x7F, OF=1, BF=0.
REQ-031 The bench SHALL apply SAR 0x80 with B=0x0B (amount 3) and check result 0xF0, PF=1; it SHALL apply SHR with the same operands and check result 0x10.
REQ-032 The bench SHALL apply opcode 15 with A=0x55, B=0xAA and check result 0x00 and all flags 0; it SHALL apply SLT with A=0xFE, B=0x01 and check result 0x01, VF=1.
REQ-033 The bench SHALL apply ROL 0x81 by 1 and check result 0x03, VF=1 with EXE_UNIT_ROTATE_EN defined, and result 0x00, VF=0 without it.
